// File: rtl/sdram_phase_sweep.sv
// ECP5 PLL dynamic-phase controller (clk_sdram domain): manual steps plus an automatic sweep that parks
// the phase at the centre of the widest passing window. Optional per-position fail log: PHASE_SWEEP_LOG_EN.
module sdram_phase_sweep #(
    parameter int N_STEPS       = 32,
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 256,
    parameter int DWELL_CYCLES  = 2**20,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               inc,
    input  logic               dec,
    input  logic [CNT_W-1:0]   failcount,
    output logic               tester_rst,
    output logic               phasedir,
    output logic               phasestep,
    output logic               phaseloadreg,
    output logic [7:0]         phase,
    output logic               busy,
    output logic               done,
    output logic               no_window,
    output logic [N_STEPS-1:0] pass_map,
    output logic [7:0]         best_lo,
    output logic [8:0]         best_len,
    input  logic [7:0]         log_addr,
    output logic [15:0]        log_data
);
    localparam int         AW   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [7:0] LAST = 8'(N_STEPS - 1);
    localparam logic [8:0] NLEN = 9'(N_STEPS);

    typedef enum logic [2:0] {IDLE, DIR, PULSE, SETTLE, DWELL, EVAL, SEEK, DONE} state_t;
    typedef enum logic [1:0] {M_MANUAL, M_SWEEP, M_SEEK} mode_t;

    state_t             state, state_nxt;
    mode_t              mode, mode_nxt;
    logic               dir_nxt;
    logic [31:0]        cnt;
    logic [8:0]         swp_k;
    logic [8:0]         run;
    logic [CNT_W-1:0]   snap, snap_cur;
    logic               pulse_last, settle_last, dwell_last, scan_last;
    logic [9:0]         scan_pos;
    logic               scan_bit, scan_upd;
    logic [8:0]         run_nxt, len_nxt;
    logic signed [10:0] lo_raw;
    logic [7:0]         lo_nxt;
    logic [9:0]         centre_sum, centre;

    function automatic logic [7:0] step_phase(input logic [7:0] p, input logic back);
        if (back)
            return (p == 8'd0) ? LAST : p - 8'd1;
        return (p == LAST) ? 8'd0 : p + 8'd1;
    endfunction

    assign pulse_last  = (cnt == 32'(PULSE_CYCLES - 1));
    assign settle_last = (cnt == 32'(SETTLE_CYCLES - 1));
    assign dwell_last  = (cnt == 32'(DWELL_CYCLES - 1));
    assign scan_last   = (cnt == 32'(2 * N_STEPS - 1));
    assign snap_cur    = (cnt == 32'd0) ? failcount : snap;

    // EVAL walks the map twice so a run crossing position N-1 -> 0 is seen whole
    assign scan_pos = (cnt[9:0] >= 10'(N_STEPS)) ? cnt[9:0] - 10'(N_STEPS) : cnt[9:0];
    assign scan_bit = pass_map[scan_pos[AW-1:0]];
    assign run_nxt  = !scan_bit ? 9'd0 : (run == NLEN) ? NLEN : run + 9'd1;
    assign scan_upd = (run_nxt > best_len);
    assign len_nxt  = scan_upd ? run_nxt : best_len;
    assign lo_raw   = $signed({1'b0, scan_pos}) + 11'sd1 - $signed({2'b00, run_nxt});
    assign lo_nxt   = (lo_raw < 0) ? 8'(lo_raw + 11'(N_STEPS)) : 8'(lo_raw);

    assign centre_sum = 10'(best_lo) + 10'(best_len >> 1);
    assign centre     = (centre_sum >= 10'(N_STEPS)) ? centre_sum - 10'(N_STEPS) : centre_sum;

    assign phasestep    = (state == PULSE);
    assign busy         = !(state inside {IDLE, DONE});
    assign phaseloadreg = 1'b0;

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        dir_nxt   = phasedir;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    mode_nxt  = M_SWEEP;
                end else if (inc ^ dec) begin
                    state_nxt = DIR;
                    mode_nxt  = M_MANUAL;
                    dir_nxt   = dec;
                end
            end
            DIR:   state_nxt = PULSE;
            PULSE: if (pulse_last) state_nxt = SETTLE;
            SETTLE: begin
                if (settle_last) begin
                    if (mode == M_MANUAL)
                        state_nxt = IDLE;
                    else if (mode == M_SEEK)
                        state_nxt = SEEK;
                    else
                        state_nxt = (swp_k == NLEN) ? EVAL : DWELL;
                end
            end
            // every tested position is followed by a forward step; the last one returns to the start
            DWELL: begin
                if (dwell_last) begin
                    state_nxt = DIR;
                    dir_nxt   = 1'b0;
                end
            end
            EVAL: begin
                if (scan_last) begin
                    state_nxt = (len_nxt == 9'd0) ? DONE : SEEK;
                    mode_nxt  = M_SEEK;
                end
            end
            SEEK: begin
                if ({2'b00, phase} == centre) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = DIR;
                    dir_nxt   = 1'b0;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode       <= M_MANUAL;
            cnt        <= 32'd0;
            phase      <= 8'd0;
            phasedir   <= 1'b0;
            tester_rst <= 1'b1;
            done       <= 1'b0;
            no_window  <= 1'b0;
            pass_map   <= '0;
            best_lo    <= 8'd0;
            best_len   <= 9'd0;
            swp_k      <= 9'd0;
            run        <= 9'd0;
        end else begin
            state      <= state_nxt;
            mode       <= mode_nxt;
            phasedir   <= dir_nxt;
            cnt        <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;
            tester_rst <= !(state_nxt inside {IDLE, DWELL, DONE});
            if (state == PULSE && pulse_last)
                phase <= step_phase(phase, phasedir);
            if (state == IDLE && start) begin
                pass_map  <= '0;
                done      <= 1'b0;
                no_window <= 1'b0;
                best_lo   <= 8'd0;
                best_len  <= 9'd0;
                swp_k     <= 9'd0;
                run       <= 9'd0;
            end
            if (state == DWELL && dwell_last) begin
                pass_map[phase[AW-1:0]] <= (failcount == snap_cur);
                swp_k                   <= swp_k + 9'd1;
            end
            if (state == EVAL) begin
                run <= run_nxt;
                if (scan_upd) begin
                    best_len <= run_nxt;
                    best_lo  <= lo_nxt;
                end
                if (scan_last)
                    no_window <= (len_nxt == 9'd0);
            end
            if (state_nxt == DONE)
                done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == DWELL && cnt == 32'd0)
            snap <= failcount;
    end

`ifdef PHASE_SWEEP_LOG_EN
    logic [15:0] log_mem [N_STEPS];

    function automatic logic [15:0] sat16(input logic [CNT_W-1:0] v);
        return (|(v >> 16)) ? 16'hFFFF : 16'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (state == DWELL && dwell_last)
            log_mem[phase[AW-1:0]] <= sat16(failcount - snap_cur);
        log_data <= ({1'b0, log_addr} < NLEN) ? log_mem[log_addr[AW-1:0]] : 16'd0;
    end
`else
    logic unused_log_addr;
    assign unused_log_addr = ^log_addr;
    assign log_data        = 16'd0;
`endif

endmodule

// File: tb/tb_sdram_phase_sweep.sv
// Scoreboard bench for sdram_phase_sweep: manual steps and randomized sweeps checked against a
// brute-force circular-window model, with a PLL position tracker and a fail-counting tester model.
`timescale 1ns/1ps
module tb_sdram_phase_sweep;
    localparam int N         = 8;
    localparam int PULSE     = 4;
    localparam int SETTLE    = 16;
    localparam int DWELL     = 64;
    localparam int STEP_BUSY = 1 + PULSE + SETTLE;

    logic         clk = 1'b0, reset = 1'b1, start = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [31:0]  failcount = 32'h1234_0000;
    logic         tester_rst, phasedir, phasestep, phaseloadreg, busy, done, no_window;
    logic [7:0]   phase, best_lo;
    logic [8:0]   best_len;
    logic [N-1:0] pass_map;
    logic [7:0]   log_addr = 8'd0;
    logic [15:0]  log_data;

    sdram_phase_sweep #(
        .N_STEPS(N), .PULSE_CYCLES(PULSE), .SETTLE_CYCLES(SETTLE), .DWELL_CYCLES(DWELL), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .inc(inc), .dec(dec), .failcount(failcount),
        .tester_rst(tester_rst), .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
        .phase(phase), .busy(busy), .done(done), .no_window(no_window), .pass_map(pass_map),
        .best_lo(best_lo), .best_len(best_len), .log_addr(log_addr), .log_data(log_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sweep; int phase; bit dir; int pulses; int busy_len;
        int pmap; int blo; int blen; bit nowin; bit done;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_err = 0;

    int        pll_pos = 0;
    bit [N-1:0] fail_mask = '0;
    int        burst [N];
    int        age = 0, burst_left = 0;
    bit        ps_q = 1'b0;

    int m_phase = 0, m_pmap = 0, m_blo = 0, m_blen = 0;
    bit m_done = 1'b0, m_nowin = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // PLL position tracker and mem_tester model: failing positions count burst errors after the snapshot
    always @(negedge clk) begin
        if (reset) begin
            pll_pos = 0;
            age     = 0;
            ps_q    = 1'b0;
        end else begin
            if (phasestep && !ps_q)
                pll_pos = phasedir ? (pll_pos + N - 1) % N : (pll_pos + 1) % N;
            ps_q = phasestep;
            if (!tester_rst && busy) begin
                age++;
                if (age == 1)
                    burst_left = fail_mask[pll_pos] ? burst[pll_pos] : 0;
                if (age >= 2 && burst_left > 0) begin
                    failcount  = failcount + 1;
                    burst_left--;
                end
            end else begin
                age = 0;
                if (!busy && !tester_rst && $urandom_range(0, 3) == 0)
                    failcount = failcount + $urandom_range(1, 50);
            end
        end
    end

    bit   busy_q = 1'b0, dir_bad = 1'b0, have_exp = 1'b0;
    int   busy_cnt = 0, pulse_cnt = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (reset) begin
            busy_q    = 1'b0;
            busy_cnt  = 0;
            pulse_cnt = 0;
            dir_bad   = 1'b0;
        end else begin
            if (busy) begin
                if (!busy_q) begin
                    busy_cnt  = 0;
                    pulse_cnt = 0;
                    dir_bad   = 1'b0;
                    have_exp  = (sb.size() > 0);
                    if (have_exp) begin
                        cur = sb[0];
                        if (!cur.sweep && phasedir != cur.dir) dir_bad = 1'b1;
                    end
                end
                busy_cnt++;
                if (phasestep) begin
                    pulse_cnt++;
                    if (have_exp && phasedir != cur.dir) dir_bad = 1'b1;
                end
            end else if (busy_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_op", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("phase", phase, cur.phase);
                    chk("pll_pos", pll_pos, cur.phase);
                    chk("phasedir", dir_bad, 0);
                    chk("tester_rst_end", tester_rst, 0);
                    chk("done", done, cur.done);
                    chk("no_window", no_window, cur.nowin);
                    chk("pass_map", pass_map, cur.pmap);
                    if (!cur.sweep) begin
                        chk("busy_len", busy_cnt, cur.busy_len);
                        chk("pulse_len", pulse_cnt, cur.pulses);
                    end else begin
                        chk("best_len", best_len, cur.blen);
                        if (!cur.nowin) chk("best_lo", best_lo, cur.blo);
                    end
                end
            end
            busy_q = busy;
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            chk("timeout", 1, 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_step(input bit back);
        exp_t e;
        m_phase    = back ? (m_phase + N - 1) % N : (m_phase + 1) % N;
        e.sweep    = 1'b0;
        e.phase    = m_phase;
        e.dir      = back;
        e.pulses   = PULSE;
        e.busy_len = STEP_BUSY;
        e.pmap     = m_pmap;
        e.blo      = m_blo;
        e.blen     = m_blen;
        e.nowin    = m_nowin;
        e.done     = m_done;
        sb.push_back(e);
        @(negedge clk);
        if (back) dec = 1'b1; else inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        wait_idle();
    endtask

    task automatic do_sweep(input bit [N-1:0] mask, input bit poke);
        exp_t       e;
        int         blo, blen, len;
        bit [N-1:0] pass;
        pass      = ~mask;
        fail_mask = mask;
        for (int i = 0; i < N; i++) burst[i] = $urandom_range(1, 5);
        burst[2] = 3;
        blo  = 0;
        blen = 0;
        for (int lo = 0; lo < N; lo++) begin
            len = 0;
            while (len < N && pass[(lo + len) % N]) len++;
            if (len > blen) begin
                blen = len;
                blo  = lo;
            end
        end
        m_pmap  = int'(pass);
        m_nowin = (blen == 0);
        m_blen  = blen;
        m_blo   = blo;
        m_done  = 1'b1;
        if (blen > 0) m_phase = (blo + blen / 2) % N;
        e.sweep    = 1'b1;
        e.phase    = m_phase;
        e.dir      = 1'b0;
        e.pulses   = 0;
        e.busy_len = 0;
        e.pmap     = m_pmap;
        e.blo      = m_blo;
        e.blen     = m_blen;
        e.nowin    = m_nowin;
        e.done     = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (40) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            inc   = 1'b1;
            @(negedge clk);
            inc   = 1'b0;
        end
        wait_idle();
`ifdef PHASE_SWEEP_LOG_EN
        for (int a = 0; a <= N; a++) begin
            log_addr = 8'(a);
            @(negedge clk);
            chk("log_data", log_data, (a < N && mask[a]) ? burst[a] : 0);
        end
`endif
    endtask

    initial begin
        int busy_seen, t;
        repeat (3) @(negedge clk);
        chk("rst_tester_rst", tester_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_phase", phase, 0);
        chk("rst_phasestep", phasestep, 0);
        chk("rst_phasedir", phasedir, 0);
        chk("rst_done", done, 0);
        chk("rst_no_window", no_window, 0);
        chk("rst_pass_map", pass_map, 0);
        chk("rst_best", {best_lo, best_len}, 0);
        chk("phaseloadreg", phaseloadreg, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_tester_rst", tester_rst, 0);
        chk("rel_busy", busy, 0);

        do_step(1'b0);
        do_step(1'b1);
        do_step(1'b1);
        do_step(1'b0);

        @(negedge clk);
        inc = 1'b1;
        dec = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        busy_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (busy || phasestep) busy_seen++;
        end
        chk("incdec_activity", busy_seen, 0);
        chk("incdec_phase", phase, m_phase);

        do_sweep(8'b1000_0011, 1'b0);
        do_sweep(8'b0001_1000, 1'b0);
        do_step(1'b0);
        do_step(1'b0);
        do_sweep(8'hFF, 1'b0);
        do_sweep(8'h00, 1'b1);

        for (int it = 0; it < 6; it++) begin
            int ns;
            ns = $urandom_range(0, 3);
            for (int s = 0; s < ns; s++) do_step(1'($urandom_range(0, 1)));
            do_sweep(N'($urandom), (it == 2));
        end

        fail_mask = 8'h0F;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(busy && !tester_rst) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("dwell_timeout", 1, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tester_rst", tester_rst, 1);
        chk("mid_rst_phase", phase, 0);
        chk("mid_rst_pass_map", pass_map, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_phasestep", phasestep, 0);
        reset   = 1'b0;
        m_phase = 0;
        m_pmap  = 0;
        m_blo   = 0;
        m_blen  = 0;
        m_nowin = 1'b0;
        m_done  = 1'b0;
        @(negedge clk);
        do_step(1'b0);
        do_sweep(8'b0100_0100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
